// File: rtl/video_fetch_arbiter.sv
// Shares one single-port framebuffer RAM between line-prefetch into a pixel-word FIFO
// and a host read/write port; video wins only while the FIFO needs refill, bounded by HOST_MAX.
module video_fetch_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned LINE_WORDS = 160,
    parameter int unsigned FB_BASE    = 0,
    parameter int unsigned FD         = 4,
    parameter int unsigned HOST_MAX   = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          line_start,
    input  logic          pix_pop,
    output logic [DW-1:0] pix_word,
    output logic          pix_valid,
    output logic          underrun,
    input  logic          h_valid,
    output logic          h_ready,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic [DW-1:0] h_rdata,
    output logic          h_rvalid,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int unsigned PW  = $clog2(FD);
    localparam int unsigned LW  = PW + 1;
    localparam int unsigned LW1 = LW + 1;
    localparam int unsigned CW  = $clog2(LINE_WORDS + 1);
    localparam int unsigned WW  = $clog2(HOST_MAX + 1);

    logic [AW-1:0] fetch_addr;
    logic [CW-1:0] line_cnt;
    logic [DW-1:0] fifo_mem [FD];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] level;
    logic          video_inflight;
    logic          host_inflight;
    logic [WW-1:0] wait_cnt;

    logic          flush;
    logic          video_elig;
    logic          host_force;
    logic          grant_v;
    logic          grant_h;
    logic          push;
    logic          pop;
    logic [PW-1:0] rd_next;
    logic [DW-1:0] head_next;

    // Video may fetch only while the line is unfinished and the FIFO has room for the returning word.
    assign flush      = frame_start | line_start;
    assign video_elig = !reset && !flush && (line_cnt < CW'(LINE_WORDS)) &&
                        ((LW1'(level) + LW1'(video_inflight)) < LW1'(FD));
    assign host_force = h_valid && (wait_cnt == WW'(HOST_MAX));
    assign grant_h    = !reset && h_valid && (host_force || !video_elig);
    assign grant_v    = video_elig && !host_force;

    assign h_ready   = grant_h;
    assign m_en      = grant_v | grant_h;
    assign m_we      = grant_h & h_we;
    assign m_addr    = grant_h ? h_addr : fetch_addr;
    assign m_wdata   = grant_h ? h_wdata : '0;
    assign pix_valid = (level != '0);

    assign push    = video_inflight && !flush;
    assign pop     = pix_pop && (level != '0) && !flush;
    assign rd_next = rd_ptr + PW'(pop);

    // pix_word tracks the head and keeps its last value once the FIFO drains.
    always_comb begin
        head_next = pix_word;
        if (!flush) begin
            if ((level - LW'(pop)) != '0) begin
                head_next = fifo_mem[rd_next];
            end else if (push) begin
                head_next = m_rdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= m_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_addr     <= AW'(FB_BASE);
            line_cnt       <= CW'(LINE_WORDS);
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            level          <= '0;
            video_inflight <= 1'b0;
            host_inflight  <= 1'b0;
            wait_cnt       <= '0;
            underrun       <= 1'b0;
            pix_word       <= '0;
            h_rdata        <= '0;
            h_rvalid       <= 1'b0;
        end else begin
            video_inflight <= grant_v;
            host_inflight  <= grant_h && !h_we;
            h_rvalid       <= host_inflight;
            if (host_inflight) begin
                h_rdata <= m_rdata;
            end

            if (!h_valid || grant_h) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WW'(HOST_MAX)) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            pix_word <= head_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                rd_ptr <= rd_next;
                level  <= level + LW'(push) - LW'(pop);
            end

            // Lines are contiguous in memory: only frame_start rewinds the fetch address.
            if (frame_start) begin
                fetch_addr <= AW'(FB_BASE);
                line_cnt   <= line_start ? '0 : CW'(LINE_WORDS);
            end else if (line_start) begin
                line_cnt <= '0;
            end else if (grant_v) begin
                fetch_addr <= fetch_addr + AW'(1);
                line_cnt   <= line_cnt + CW'(1);
            end

            if (frame_start) begin
                underrun <= 1'b0;
            end else if (!line_start && pix_pop && (level == '0)) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule
